// File: rtl/alu_ctl_seq.sv
// Issue sequencer between decode and the combinational ALU: decodes one
// instruction slice into an ALU CTL code, drives registered operands, returns the result.
module alu_ctl_seq #(
    parameter int WORDSIZE = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [6:0]          i_opcode,
    input  logic [2:0]          i_funct3,
    input  logic                i_funct7_5,
    input  logic [WORDSIZE-1:0] i_rs1,
    input  logic [WORDSIZE-1:0] i_rs2,
    input  logic [WORDSIZE-1:0] i_imm,
    output logic [WORDSIZE-1:0] o_alu_a,
    output logic [WORDSIZE-1:0] o_alu_b,
    output logic [3:0]          o_alu_ctl,
    input  logic [WORDSIZE-1:0] i_alu_r,
    input  logic                i_alu_z,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [WORDSIZE-1:0] o_out_r,
    output logic                o_out_taken,
    output logic                o_out_illegal
);

    // state | meaning
    // IDLE  | ready for a new instruction slice
    // EXEC  | operands on the ALU, result captured at the next edge
    // DONE  | result held until the consumer takes it
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;

    state_t              r_state;
    logic [WORDSIZE-1:0] r_alu_a;
    logic [WORDSIZE-1:0] r_alu_b;
    logic [3:0]          r_alu_ctl;
    logic                r_is_branch;
    logic                r_is_bne;
    logic                r_out_valid;
    logic [WORDSIZE-1:0] r_out_r;
    logic                r_out_taken;
    logic                r_out_illegal;

    logic       w_legal;
    logic [3:0] w_ctl;
    logic       w_use_imm;
    logic       w_branch;
    logic       w_bne;

    always_comb begin
        w_legal   = 1'b0;
        w_ctl     = CTL_AND;
        w_use_imm = 1'b0;
        w_branch  = 1'b0;
        w_bne     = 1'b0;
        case (i_opcode)
            7'b0110011: begin
                case (i_funct3)
                    3'b000: begin
                        w_legal = 1'b1;
                        w_ctl   = i_funct7_5 ? CTL_SUB : CTL_ADD;
                    end
                    3'b111: begin
                        w_legal = 1'b1;
                        w_ctl   = CTL_AND;
                    end
                    3'b110: begin
                        w_legal = 1'b1;
                        w_ctl   = CTL_OR;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                w_use_imm = 1'b1;
                case (i_funct3)
                    3'b000: begin
                        w_legal = 1'b1;
                        w_ctl   = CTL_ADD;
                    end
                    3'b111: begin
                        w_legal = 1'b1;
                        w_ctl   = CTL_AND;
                    end
                    3'b110: begin
                        w_legal = 1'b1;
                        w_ctl   = CTL_OR;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0000011, 7'b0100011: begin
                w_legal   = 1'b1;
                w_ctl     = CTL_ADD;
                w_use_imm = 1'b1;
            end
            7'b1100011: begin
                w_ctl    = CTL_SUB;
                w_branch = 1'b1;
                case (i_funct3)
                    3'b000: w_legal = 1'b1;
                    3'b001: begin
                        w_legal = 1'b1;
                        w_bne   = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctl     <= CTL_AND;
            r_is_branch   <= 1'b0;
            r_is_bne      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_r       <= '0;
            r_out_taken   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        if (w_legal) begin
                            r_alu_a     <= i_rs1;
                            r_alu_b     <= w_use_imm ? i_imm : i_rs2;
                            r_alu_ctl   <= w_ctl;
                            r_is_branch <= w_branch;
                            r_is_bne    <= w_bne;
                            r_state     <= S_EXEC;
                        end else begin
                            // ALU inputs are deliberately left at the previous op's values
                            r_out_illegal <= 1'b1;
                            r_out_r       <= '0;
                            r_out_taken   <= 1'b0;
                            r_out_valid   <= 1'b1;
                            r_state       <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    r_out_r       <= i_alu_r;
                    r_out_taken   <= r_is_branch & (r_is_bne ? ~i_alu_z : i_alu_z);
                    r_out_illegal <= 1'b0;
                    r_out_valid   <= 1'b1;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready    = (r_state == S_IDLE);
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_ctl     = r_alu_ctl;
    assign o_out_valid   = r_out_valid;
    assign o_out_r       = r_out_r;
    assign o_out_taken   = r_out_taken;
    assign o_out_illegal = r_out_illegal;

endmodule

// File: doc/alu_ctl_seq.md
# alu_ctl_seq

Multi-cycle issue sequencer that drives the combinational ALU: it accepts one decoded RISC-V instruction slice (opcode, funct3, funct7 bit 5, operands) over a valid/ready handshake and translates it into the ALU's 4-bit CTL code. It presents registered operands to the ALU, captures R and Z one cycle later, and returns the result, the branch-taken flag and an illegal-op flag over a second valid/ready handshake. It sits between the decode stage and the ALU and is the only block that drives the ALU's A, B and CTL inputs.

## Interface
- WORDSIZE, 32, datapath width of operands, immediate and result.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous reset, active-low.
- IN_VALID  in  1  instruction slice present.
- IN_READY  out  1  sequencer can accept; high only in IDLE.
- OPCODE  in  7  instruction bits [6:0].
- FUNCT3  in  3  instruction bits [14:12].
- FUNCT7_5  in  1  instruction bit 30.
- RS1  in  WORDSIZE  first source operand.
- RS2  in  WORDSIZE  second source operand.
- IMM  in  WORDSIZE  sign-extended immediate, produced upstream.
- ALU_A  out  WORDSIZE  registered ALU operand A.
- ALU_B  out  WORDSIZE  registered ALU operand B.
- ALU_CTL  out  4  registered ALU control code.
- ALU_R  in  WORDSIZE  ALU result (combinational from ALU_A/ALU_B/ALU_CTL).
- ALU_Z  in  1  ALU zero flag (ALU_R == 0).
- OUT_VALID  out  1  result held.
- OUT_READY  in  1  consumer accepts result.
- OUT_R  out  WORDSIZE  captured result.
- OUT_TAKEN  out  1  branch condition true.
- OUT_ILLEGAL  out  1  unsupported encoding.

## Operation
- CTL codes: AND = 4'b0000, OR = 4'b0001, ADD = 4'b0010, SUB = 4'b0110. No other codes are ever driven.
- Decode table:
  - OPCODE 0110011 (R-type): B=RS2.
    - FUNCT3 000 gives ADD when FUNCT7_5=0 and SUB when FUNCT7_5=1.
    - FUNCT3 111 gives AND; 110 gives OR.
  - OPCODE 0010011 (I-type): B=IMM.
    - FUNCT3 000 gives ADD, 111 gives AND, 110 gives OR.
    - FUNCT7_5 is ignored.
  - OPCODE 0000011 / 0100011 (load/store address): ADD, B=IMM, FUNCT3 ignored.
  - OPCODE 1100011 (branch): SUB, B=RS2.
    - FUNCT3 000 (BEQ) sets TAKEN=ALU_Z.
    - FUNCT3 001 (BNE) sets TAKEN=!ALU_Z.
  - A=RS1 in every legal case.
  - Any other OPCODE/FUNCT3 combination is illegal.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: IN_READY=1. On IN_VALID:
    - legal: latch ALU_A, ALU_B, ALU_CTL; go to EXEC.
    - illegal: leave ALU_A, ALU_B, ALU_CTL unchanged; set OUT_ILLEGAL=1, OUT_R=0, OUT_TAKEN=0, OUT_VALID=1; go to DONE.
  - EXEC: capture OUT_R=ALU_R; OUT_TAKEN per branch rule (0 for non-branch); OUT_ILLEGAL=0; OUT_VALID=1; go to DONE.
  - DONE: hold all OUT_* stable while OUT_READY=0. On OUT_READY=1: clear OUT_VALID; go to IDLE.
- IN_VALID is ignored outside IDLE. Inputs are sampled only at the accepting edge.
- Arithmetic is modulo 2^WORDSIZE (the ALU's wrap). No overflow flag is produced.

## Timing
- Reset (RST_N low, asynchronous): state IDLE, IN_READY=1, all other outputs 0 (ALU_CTL=4'b0000). The in-flight operation and any held result are discarded.
- Legal op accepted at edge k: ALU inputs change after edge k; OUT_VALID rises after edge k+1.
- Illegal op accepted at edge k: OUT_VALID rises after edge k.
- Result handshake completes at the first edge with OUT_VALID&&OUT_READY.
  - OUT_VALID falls after that edge; IN_READY rises in the same cycle.
- Maximum throughput is one legal op per 3 cycles when OUT_READY is held high.
- ALU_A/ALU_B/ALU_CTL hold their last value between ops (no glitch back to 0).
- RST_N deasserted mid-cycle: first acceptance occurs at the first rising edge with RST_N high.

## Test plan
- WORDSIZE=4, R-type ADD, RS1=7, RS2=5, OUT_READY=1 -> ALU_CTL=0010; OUT_R=12, OUT_TAKEN=0, OUT_VALID exactly 2 edges after accept.
- WORDSIZE=4, ADDI RS1=9, IMM=9 -> OUT_R=2 (wrap), OUT_ILLEGAL=0.
- BEQ RS1=5, RS2=5 -> ALU_CTL=0110, OUT_R=0, OUT_TAKEN=1; BNE with the same operands -> OUT_TAKEN=0; BNE RS1=3, RS2=6 -> OUT_TAKEN=1.
- OR RS1=3, RS2=6 with OUT_READY held 0 for 5 cycles -> OUT_R=7 stable, IN_READY=0 throughout, a second IN_VALID is ignored; releasing OUT_READY returns to IDLE.
- Illegal opcode 1111111, and R-type FUNCT3=001 -> OUT_ILLEGAL=1, OUT_R=0, OUT_VALID one edge after accept, ALU_CTL unchanged.
- RST_N pulsed low while in EXEC -> all outputs 0 immediately, IN_READY=1, no OUT_VALID for the aborted op.
